cobra_drive_burst: RTL and testbench
====================================

Name: cobra_drive_burst

Overview:
- Consumes the divided drive clock `step_clk`, produced by a flop in the `in_clk` domain.
- Produces a burst of N complementary drive periods on `drive_a`/`drive_b`, with programmable dead time between phases.
- Runs a start/busy/done handshake toward the command logic.
- Sits between the drive-frequency divider and the motor driver output pins on the driver board.

Parameters:
- COUNT_W, 16: width of the `pulse_count` and `pulses_left` period counters.
- DEADTIME_CYCLES, 4: `in_clk` cycles with both outputs low after each `step_clk` edge. Must be less than the `step_clk` half-period in `in_clk` cycles (26 at 16 MHz/300 kHz).

Ports:
- in_clk, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- step_clk, input, 1: divided drive clock, registered in the `in_clk` domain; no synchronizer needed.
- start, input, 1: one-cycle request; honoured only in IDLE.
- dir, input, 1: 0 = `drive_a` on the `step_clk` high phase; 1 = `drive_b` on the high phase. Latched at start.
- pulse_count, input, COUNT_W: number of periods; latched at start.
- abort, input, 1: terminate burst immediately.
- drive_a, output, 1: phase A drive.
- drive_b, output, 1: phase B drive.
- busy, output, 1: high in ARM and RUN.
- done, output, 1: one-cycle completion pulse.
- aborted, output, 1: set on abort; cleared by the next accepted start.
- pulses_left, output, COUNT_W: periods remaining.

Behaviour:
- Reset (`reset_n` low, async): state IDLE; all outputs 0; latched count/dir 0.
- Edge detect: `step_q` <= `step_clk`; rise = `step_clk & ~step_q`; fall = `~step_clk & step_q`. An edge is "detected in cycle k".
- All outputs are registered.
- IDLE:
  - start with `pulse_count` != 0: latch count/dir, `pulses_left` <= `pulse_count`, go to ARM; `busy` = 1 next cycle; clear `aborted`.
  - start with `pulse_count` == 0: `done` = 1 next cycle, stay IDLE, no drive.
- ARM: wait for a rise, so bursts are phase-aligned. On rise detected in cycle k, go to RUN with phase = HIGH and load the dead-time counter.
- RUN, phase HIGH:
  - Both drives 0 from k+1 through k+DEADTIME_CYCLES.
  - Primary drive (`drive_a` if `dir`=0, else `drive_b`) asserts at k+1+DEADTIME_CYCLES and holds until a fall.
- RUN, phase LOW:
  - On a fall detected in cycle j: both drives 0 from j+1.
  - Secondary drive asserts at j+1+DEADTIME_CYCLES and holds until the next rise.
- DEADTIME_CYCLES = 0: the opposite drive asserts at k+1; no overlap.
- Rise detected in RUN:
  - If `pulses_left` > 1: decrement, start a new HIGH phase.
  - If `pulses_left` == 1: `pulses_left` <= 0, go to IDLE, drives 0 at k+1, `done` = 1 at k+1, `busy` = 0 at k+1.
- Burst length: exactly N full `step_clk` periods, from the ARM rise to the N-th following rise.
- Invariant: `drive_a` & `drive_b` is never 1 in any cycle, including across abort and reset.
- start while `busy`: ignored; no latch change.
- abort in ARM/RUN: next cycle → IDLE, drives 0, `busy` 0, `aborted` 1, `done` 1 (one cycle), `pulses_left` holds its value.
- abort in IDLE: no effect.
- abort and start in the same cycle: abort wins.
- abort and final rise in the same cycle: treated as abort (`aborted` = 1).
- `reset_n` asserted mid-burst: drives drop asynchronously, no `done` pulse.
- Dead-time counter width: `$clog2(DEADTIME_CYCLES+1)`, minimum 1. Reloaded on every detected edge; an edge arriving during dead time restarts it with the new phase.

Decomposition:
- Package `drive_pkg`:
  - `burst_state_t` enum: IDLE, ARM, RUN.
  - `phase_t` enum: HIGH, LOW.
  - default COUNT_W and DEADTIME_CYCLES constants.
- Sub-module `deadtime_timer`: load on edge, counts down, outputs `expired`. Instantiated once.
- Edge detect and FSM live in the top module.

Test Plan:
- `step_clk` half-period 26 cycles, start with `pulse_count`=3, `dir`=0 → 3 periods. Each `drive_a` high window = 22 cycles, starting 5 cycles after the rise is detected (dead time 4 + 1 register stage). Each `drive_b` window = 22 cycles. `done` fires 1 cycle after the 3rd rise following ARM; `busy` is high throughout.
- `dir`=1, `pulse_count`=1 → only `drive_b` in the high phase and `drive_a` in the low phase; `pulses_left` 1→0; single `done`.
- `pulse_count`=0 start → `done` next cycle, `busy` never 1, drives stay 0.
- abort 10 cycles into the 2nd period of a 5-period burst → drives 0 and `busy` 0 next cycle; `aborted`=1; `done` pulse; `pulses_left`=4. A later start clears `aborted`.
- start re-pulsed while `busy`, plus `reset_n` low mid-RUN → second start ignored (`pulses_left` unchanged); reset forces all outputs 0 immediately with no `done`. Assert `drive_a` & `drive_b` == 0 every cycle throughout.
- DEADTIME_CYCLES=0 build → drive swaps at k+1 with no overlap; burst of 2 completes correctly.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared types and defaults for the drive burst generator.
package drive_pkg;

  localparam int DEF_COUNT_W         = 16;
  localparam int DEF_DEADTIME_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } burst_state_t;

  typedef enum logic {
    HIGH = 1'b0,
    LOW  = 1'b1
  } phase_t;

  // Dead-time counter width: enough to hold DEADTIME_CYCLES, never zero bits.
  function automatic int dt_width(input int cycles);
    if (cycles < 1) return 1;
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/deadtime_timer.sv
// Dead-time down-counter: reloaded on every step_clk edge, counts to zero.
// o_expired reports whether the counter will read zero after the coming
// clock edge, so the caller can register drive outputs off it directly.
module deadtime_timer
  import drive_pkg::*;
#(
  parameter int DEADTIME_CYCLES = DEF_DEADTIME_CYCLES
) (
  input  logic in_clk,
  input  logic reset_n,
  input  logic i_load,
  output logic o_expired
);

  localparam int                CNT_W    = dt_width(DEADTIME_CYCLES);
  localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(DEADTIME_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next count: reload on an edge, otherwise count down and stick at zero.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = LOAD_VAL;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_expired = (w_cnt_nxt == '0);

endmodule

// File: rtl/cobra_drive_burst.sv
// Burst generator for the motor driver pins: emits N complementary drive
// periods on drive_a/drive_b, phase-aligned to step_clk rises, with dead
// time after every step_clk edge. start/busy/done handshake to command logic.
module cobra_drive_burst
  import drive_pkg::*;
#(
  parameter int COUNT_W         = DEF_COUNT_W,
  parameter int DEADTIME_CYCLES = DEF_DEADTIME_CYCLES
) (
  input  logic               in_clk,
  input  logic               reset_n,
  input  logic               step_clk,
  input  logic               start,
  input  logic               dir,
  input  logic [COUNT_W-1:0] pulse_count,
  input  logic               abort,
  output logic               drive_a,
  output logic               drive_b,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [COUNT_W-1:0] pulses_left
);

  burst_state_t       r_state;
  burst_state_t       w_state_nxt;
  phase_t             r_phase;
  phase_t             w_phase_nxt;
  logic               r_step_q;
  logic               r_dir;
  logic               w_dir_nxt;
  logic [COUNT_W-1:0] r_pulses_left;
  logic [COUNT_W-1:0] w_pulses_nxt;
  logic               r_aborted;
  logic               w_aborted_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_drive_a;
  logic               w_drive_a_nxt;
  logic               r_drive_b;
  logic               w_drive_b_nxt;
  logic               w_rise;
  logic               w_fall;
  logic               w_dt_load;
  logic               w_dt_expired;
  logic               w_drive_on;

  // step_clk already comes from a flop in this domain, so one register is
  // enough to find its edges.
  assign w_rise    = step_clk & ~r_step_q;
  assign w_fall    = ~step_clk & r_step_q;
  assign w_dt_load = w_rise | w_fall;

  deadtime_timer #(
    .DEADTIME_CYCLES(DEADTIME_CYCLES)
  ) u_deadtime (
    .in_clk   (in_clk),
    .reset_n  (reset_n),
    .i_load   (w_dt_load),
    .o_expired(w_dt_expired)
  );

  // State and registered outputs; reset drops the drives asynchronously.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step_q      <= 1'b0;
      r_state       <= IDLE;
      r_phase       <= HIGH;
      r_dir         <= 1'b0;
      r_pulses_left <= '0;
      r_aborted     <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_drive_a     <= 1'b0;
      r_drive_b     <= 1'b0;
    end else begin
      r_step_q      <= step_clk;
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_dir         <= w_dir_nxt;
      r_pulses_left <= w_pulses_nxt;
      r_aborted     <= w_aborted_nxt;
      r_done        <= w_done_nxt;
      r_busy        <= w_busy_nxt;
      r_drive_a     <= w_drive_a_nxt;
      r_drive_b     <= w_drive_b_nxt;
    end
  end

  // Burst sequencing: accept start in IDLE, align on a rise in ARM, count
  // periods on rises in RUN. abort takes priority over everything else,
  // including a start or the final rise in the same cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_dir_nxt     = r_dir;
    w_pulses_nxt  = r_pulses_left;
    w_aborted_nxt = r_aborted;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          if (pulse_count != '0) begin
            w_state_nxt   = ARM;
            w_dir_nxt     = dir;
            w_pulses_nxt  = pulse_count;
            w_aborted_nxt = 1'b0;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      ARM: begin
        if (abort) begin
          w_state_nxt   = IDLE;
          w_aborted_nxt = 1'b1;
          w_done_nxt    = 1'b1;
        end else if (w_rise) begin
          w_state_nxt = RUN;
          w_phase_nxt = HIGH;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt   = IDLE;
          w_aborted_nxt = 1'b1;
          w_done_nxt    = 1'b1;
        end else if (w_rise) begin
          if (r_pulses_left > COUNT_W'(1)) begin
            w_pulses_nxt = r_pulses_left - COUNT_W'(1);
            w_phase_nxt  = HIGH;
          end else begin
            w_pulses_nxt = '0;
            w_state_nxt  = IDLE;
            w_done_nxt   = 1'b1;
          end
        end else if (w_fall) begin
          w_phase_nxt = LOW;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Drive/busy next values. Both drives come from one enable split by a
  // single phase/dir comparison, so they can never be high together.
  always_comb begin
    w_busy_nxt    = (w_state_nxt != IDLE);
    w_drive_on    = (w_state_nxt == RUN) && w_dt_expired;
    w_drive_a_nxt = w_drive_on && ((w_phase_nxt == HIGH) != r_dir);
    w_drive_b_nxt = w_drive_on && ((w_phase_nxt == HIGH) == r_dir);
  end

  assign drive_a     = r_drive_a;
  assign drive_b     = r_drive_b;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign pulses_left = r_pulses_left;

endmodule

// File: tb/tb_cobra_drive_burst.sv
// Bench for cobra_drive_burst: a DEADTIME_CYCLES=4 and a DEADTIME_CYCLES=0
// instance run side by side on the same stimulus. Expected outputs come from
// a timeline model keyed on the bench's own step_clk schedule.
module tb_cobra_drive_burst;

  localparam int CW    = 16;
  localparam int HALF  = 26;
  localparam int PER   = 2 * HALF;
  localparam int ALIGN = 10;
  localparam int T0    = PER - ALIGN;

  typedef struct packed {
    logic          a;
    logic          b;
    logic          busy;
    logic          done;
    logic          ab;
    logic [CW-1:0] left;
  } exp_t;

  typedef struct {
    int n;
    bit d;
    bit has_ab;
    int ab_off;
    int exp_left;
    bit exp_ab;
  } vec_t;

  logic in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  logic          reset_n;
  logic          step_clk;
  logic          start;
  logic          dir;
  logic [CW-1:0] pulse_count;
  logic          abort;
  logic          drive_a, drive_b, busy, done, aborted;
  logic [CW-1:0] pulses_left;
  logic          z_drive_a, z_drive_b, z_busy, z_done, z_aborted;
  logic [CW-1:0] z_pulses_left;

  cobra_drive_burst #(.COUNT_W(CW), .DEADTIME_CYCLES(4)) u_dut4 (
    .in_clk(in_clk), .reset_n(reset_n), .step_clk(step_clk), .start(start),
    .dir(dir), .pulse_count(pulse_count), .abort(abort),
    .drive_a(drive_a), .drive_b(drive_b), .busy(busy), .done(done),
    .aborted(aborted), .pulses_left(pulses_left)
  );

  cobra_drive_burst #(.COUNT_W(CW), .DEADTIME_CYCLES(0)) u_dut0 (
    .in_clk(in_clk), .reset_n(reset_n), .step_clk(step_clk), .start(start),
    .dir(dir), .pulse_count(pulse_count), .abort(abort),
    .drive_a(z_drive_a), .drive_b(z_drive_b), .busy(z_busy), .done(z_done),
    .aborted(z_aborted), .pulses_left(z_pulses_left)
  );

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  int            sphase = 0;
  logic [CW-1:0] m_left;
  bit            m_ab;
  exp_t          q4[$];
  exp_t          q0[$];
  vec_t          vecs[6];

  function automatic void chk(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got a=%b b=%b busy=%b done=%b aborted=%b left=%0d, want a=%b b=%b busy=%b done=%b aborted=%b left=%0d",
               name, act.a, act.b, act.busy, act.done, act.ab, act.left,
               exp.a, exp.b, exp.busy, exp.done, exp.ab, exp.left);
    end
  endfunction

  function automatic void chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endfunction

  // Expected outputs t cycles after the start cycle (t<0: idle before start).
  // t0 = first rise seen in ARM, endt = cycle of the final rise or abort.
  function automatic exp_t model(input int t, input int n, input bit d, input int t0,
                                 input int endt, input bit is_ab,
                                 input logic [CW-1:0] prev_left, input bit prev_ab,
                                 input int dt);
    exp_t e;
    int   r;
    int   lx;
    e      = '0;
    e.ab   = prev_ab;
    e.left = prev_left;
    if (t < 0) return e;
    if (n == 0) begin
      e.done = (t == 0);
      return e;
    end
    if (t < endt) begin
      e.busy = 1'b1;
      e.ab   = 1'b0;
      if (t < t0) begin
        e.left = CW'(n);
      end else begin
        r      = (t - t0) % PER;
        e.left = CW'(n - (t - t0) / PER);
        if (r < HALF) begin
          if (r >= dt) begin e.a = ~d; e.b = d; end
        end else if (r - HALF >= dt) begin
          e.a = d; e.b = ~d;
        end
      end
    end else begin
      e.done = (t == endt);
      e.ab   = is_ab;
      lx     = endt - 1;
      if (!is_ab)       e.left = '0;
      else if (lx < t0) e.left = CW'(n);
      else              e.left = CW'(n - (lx - t0) / PER);
    end
    return e;
  endfunction

  task automatic cycle(input exp_t e4, input exp_t e0);
    exp_t x;
    q4.push_back(e4);
    q0.push_back(e0);
    @(posedge in_clk);
    #1;
    cyc++;
    x = q4.pop_front();
    chk($sformatf("dt4_cyc%0d", cyc), {drive_a, drive_b, busy, done, aborted, pulses_left}, x);
    x = q0.pop_front();
    chk($sformatf("dt0_cyc%0d", cyc), {z_drive_a, z_drive_b, z_busy, z_done, z_aborted, z_pulses_left}, x);
    sphase   = (sphase + 1) % PER;
    step_clk = (sphase < HALF);
  endtask

  task automatic align();
    exp_t idle;
    idle  = model(-1, 0, 1'b0, 0, 0, 1'b0, m_left, m_ab, 0);
    start = 1'b0;
    abort = 1'b0;
    for (int g = 0; g < PER && sphase != ALIGN; g++) cycle(idle, idle);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int endt;
    int dcount;
    align();
    pulse_count = CW'(v.n);
    dir         = v.d;
    dcount      = 0;
    if (v.n == 0)      endt = 0;
    else if (v.has_ab) endt = T0 + v.ab_off;
    else               endt = T0 + v.n * PER;
    for (int t = 0; t <= endt + 3; t++) begin
      start = (t == 0);
      abort = (v.has_ab && (t == endt)) || (t == endt + 1);
      cycle(model(t, v.n, v.d, T0, endt, v.has_ab, m_left, m_ab, 4),
            model(t, v.n, v.d, T0, endt, v.has_ab, m_left, m_ab, 0));
      if (done) dcount++;
    end
    start = 1'b0;
    abort = 1'b0;
    chk_int($sformatf("vec%0d_left", idx), int'(pulses_left), v.exp_left);
    chk_int($sformatf("vec%0d_aborted", idx), int'(aborted), int'(v.exp_ab));
    chk_int($sformatf("vec%0d_done_pulses", idx), dcount, 1);
    m_left = CW'(v.exp_left);
    m_ab   = v.exp_ab;
  endtask

  // Drives must never overlap, in either build, in any cycle.
  always @(negedge in_clk) begin
    checks++;
    if (drive_a && drive_b) begin
      errors++;
      $display("FAIL overlap_dt4: got a=1 b=1, want not both high");
    end
    checks++;
    if (z_drive_a && z_drive_b) begin
      errors++;
      $display("FAIL overlap_dt0: got a=1 b=1, want not both high");
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want summary reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   endt;
    exp_t e;

    vecs[0] = '{3, 1'b0, 1'b0, 0,        0, 1'b0};
    vecs[1] = '{1, 1'b1, 1'b0, 0,        0, 1'b0};
    vecs[2] = '{0, 1'b0, 1'b0, 0,        0, 1'b0};
    vecs[3] = '{5, 1'b0, 1'b1, PER + 10, 4, 1'b1};
    vecs[4] = '{2, 1'b1, 1'b0, 0,        0, 1'b0};
    vecs[5] = '{2, 1'b0, 1'b1, -2,       2, 1'b1};

    reset_n     = 1'b0;
    start       = 1'b0;
    dir         = 1'b0;
    abort       = 1'b0;
    pulse_count = '0;
    sphase      = 0;
    step_clk    = 1'b1;
    m_left      = '0;
    m_ab        = 1'b0;

    repeat (3) @(posedge in_clk);
    #1;
    chk("reset_dt4", {drive_a, drive_b, busy, done, aborted, pulses_left}, '0);
    chk("reset_dt0", {z_drive_a, z_drive_b, z_busy, z_done, z_aborted, z_pulses_left}, '0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Restart while busy is ignored; then reset in the middle of a driven phase.
    align();
    pulse_count = CW'(3);
    dir         = 1'b0;
    endt        = T0 + 3 * PER;
    for (int t = 0; t <= T0 + PER + 30; t++) begin
      start = (t == 0) || (t == T0 + 5);
      if (t == T0 + 5) begin
        pulse_count = CW'(7);
        dir         = 1'b1;
      end
      cycle(model(t, 3, 1'b0, T0, endt, 1'b0, m_left, m_ab, 4),
            model(t, 3, 1'b0, T0, endt, 1'b0, m_left, m_ab, 0));
    end
    start = 1'b0;
    chk_int("restart_left", int'(pulses_left), 2);
    chk_int("restart_drive_b_on", int'(drive_b), 1);

    reset_n = 1'b0;
    #1;
    chk("async_reset_dt4", {drive_a, drive_b, busy, done, aborted, pulses_left}, '0);
    chk("async_reset_dt0", {z_drive_a, z_drive_b, z_busy, z_done, z_aborted, z_pulses_left}, '0);
    repeat (2) begin
      @(posedge in_clk);
      #1;
      chk("held_reset_dt4", {drive_a, drive_b, busy, done, aborted, pulses_left}, '0);
    end
    reset_n = 1'b1;
    m_left  = '0;
    m_ab    = 1'b0;
    e       = model(-1, 0, 1'b0, 0, 0, 1'b0, m_left, m_ab, 0);
    for (int t = 0; t < 4; t++) cycle(e, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
